jts16_obj_draw: RTL
===================

JTS16_OBJ_DRAW -- requirements
Module: jts16_obj_draw

Interface
REQ-001 SHALL have parameter MAXW, default 128, meaning the maximum number of ROM words fetched per draw command.
REQ-002 SHALL have port clk  in  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  in  1  one-cycle draw request from the object scanner.
REQ-005 SHALL have port busy  out  1  high while a command is being processed.
REQ-006 SHALL have port xpos  in  9  first screen column of the object line.
REQ-007 SHALL have port offset  in  16  word offset; bit 15 is the flip flag, bits 14:0 are the start address.
REQ-008 SHALL have ports bank (in, 4, ROM bank), prio (in, 2, priority) and pal (in, 6, palette).
REQ-009 SHALL have port obj_addr  out  19  ROM word address {bank, addr[14:0]}.
REQ-010 SHALL have port obj_cs  out  1  ROM request strobe.
REQ-011 SHALL have ports obj_ok (in, 1, ROM data valid) and obj_data (in, 16, four 4-bit pixels).
REQ-012 SHALL have port buf_addr  out  9  line-buffer column.
REQ-013 SHALL have ports buf_data (out, 12, {prio, pal, pix}) and buf_we (out, 1, line-buffer write strobe).

Function
REQ-014 SHALL implement the states IDLE, REQ and PIX, with a 2-bit pixel counter used in PIX.
REQ-015 IDLE: start=1 SHALL latch xpos, offset, bank, prio and pal, clear the word counter, and enter REQ; busy SHALL be 1 from the next cycle.
REQ-016 SHALL ignore start while busy=1, with no change to any latched value.
REQ-017 REQ: obj_cs SHALL be 1 and obj_addr SHALL be {bank, addr}; data SHALL be accepted only when obj_ok=1 and obj_cs was already 1 in the previous cycle.
REQ-018 On acceptance, SHALL latch obj_data, drop obj_cs, increment the word counter and enter PIX with pixel counter 0.
REQ-019 PIX, flip=0: pixel order SHALL be data[15:12], [11:8], [7:4], [3:0].
REQ-020 PIX, flip=1: pixel order SHALL be data[3:0], [7:4], [11:8], [15:12].
REQ-021 One pixel SHALL be processed per cycle, so each word takes 4 PIX cycles.
REQ-022 Pixel 0: SHALL be transparent, buf_we=0, column still advances.
REQ-023 Pixel 1..14: buf_we=1, buf_addr=column, buf_data={prio, pal, pix}.
REQ-024 Pixel 15: SHALL be the end marker; no write; go to IDLE next cycle; remaining pixels discarded.
REQ-025 Column SHALL start at xpos and increment by 1 per processed pixel, wrapping modulo 512.
REQ-026 After the 4th pixel: addr SHALL become addr+1 when flip=0 or addr-1 when flip=1, as 15-bit wrap-around arithmetic, and the state SHALL return to REQ.
REQ-027 If the word counter equals MAXW after the 4th pixel, the state SHALL go to IDLE.
REQ-028 busy SHALL be 0 exactly when the state is IDLE.
REQ-029 buf_we SHALL be a single-cycle strobe per pixel and SHALL be 0 outside PIX.
REQ-030 obj_ok arriving outside REQ SHALL be ignored.
REQ-031 start asserted in the same cycle busy falls SHALL be ignored; a new command is accepted only while busy=0 is registered.

Reset
REQ-032 rst_n=0 SHALL force state IDLE and busy, obj_cs and buf_we to 0, and obj_addr, buf_addr and buf_data to 0, at any time including mid-fetch or mid-pixel.
REQ-033 After rst_n is released, no write or ROM request SHALL occur until a new start.

Verification
REQ-034 Bench SHALL cover: start with xpos=0x010, offset=0x0100, bank=2, prio=1, pal=0x05; ROM returns 0x1230 then 0x4F00 -> obj_addr=0x10100 then 0x10101; writes at columns 0x010, 0x011, 0x012 (pix 1, 2, 3) and 0x014 (pix 4); no write at 0x013; pixel F ends the command; busy=0 afterwards.
REQ-035 Bench SHALL cover: same command with offset=0x8100 and ROM returning 0x0321 then 0xF000 -> pixels 1, 2, 3 written at 0x010..0x012; second fetch at address 0x100-1=0x0FF; F ends the command.
REQ-036 Bench SHALL cover: obj_ok held at 1 before start -> no data accepted in the first REQ cycle; data accepted on the 2nd REQ cycle at the earliest.
REQ-037 Bench SHALL cover: ROM always returns 0x1111 -> exactly MAXW=128 fetches and 512 writes; columns wrap from 0x1FF to 0x000; busy falls afterwards.
REQ-038 Bench SHALL cover: start pulsed while busy, with different xpos -> ignored; the original command completes unchanged.
REQ-039 Bench SHALL cover: rst_n=0 during PIX -> busy, obj_cs and buf_we are 0 immediately (asynchronously); the next start draws normally.

Source files
------------

// File: rtl/jts16_obj_draw.sv
// Object line drawer: fetches 16-bit ROM words (four 4-bit pixels each) and
// writes the opaque pixels into the line buffer, one pixel per clock.
module jts16_obj_draw #(
    parameter int MAXW = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    input  logic [8:0]  xpos,
    input  logic [15:0] offset,
    input  logic [3:0]  bank,
    input  logic [1:0]  prio,
    input  logic [5:0]  pal,
    output logic [18:0] obj_addr,
    output logic        obj_cs,
    input  logic        obj_ok,
    input  logic [15:0] obj_data,
    output logic [8:0]  buf_addr,
    output logic [11:0] buf_data,
    output logic        buf_we
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_PIX  = 2'd2;

    localparam int             WCW    = $clog2(MAXW + 1);
    localparam logic [WCW-1:0] MAXW_W = WCW'(MAXW);

    logic [1:0]     state_q,    state_d;
    logic [1:0]     pix_cnt_q,  pix_cnt_d;
    logic [WCW-1:0] word_cnt_q, word_cnt_d;
    logic [14:0]    addr_q,     addr_d;
    logic           flip_q,     flip_d;
    logic [3:0]     bank_q,     bank_d;
    logic [1:0]     prio_q,     prio_d;
    logic [5:0]     pal_q,      pal_d;
    logic [8:0]     col_q,      col_d;
    logic [15:0]    data_q,     data_d;
    logic           obj_cs_q,   obj_cs_d;
    logic           cs_prev_q,  cs_prev_d;
    logic [18:0]    obj_addr_q, obj_addr_d;

    logic [1:0] nib_sel;
    logic [3:0] pix;
    logic       in_pix;

    // Flipped objects read the word from its low nibble upwards.
    assign nib_sel = flip_q ? pix_cnt_q : ~pix_cnt_q;

    always_comb begin
        pix = 4'd0;
        case (nib_sel)
            2'd0:    pix = data_q[3:0];
            2'd1:    pix = data_q[7:4];
            2'd2:    pix = data_q[11:8];
            default: pix = data_q[15:12];
        endcase
    end

    assign in_pix   = (state_q == ST_PIX);
    assign busy     = (state_q != ST_IDLE);
    assign obj_cs   = obj_cs_q;
    assign obj_addr = obj_addr_q;
    // Buffer outputs are gated by the state so reset clears them at once.
    assign buf_we   = in_pix && (pix != 4'h0) && (pix != 4'hF);
    assign buf_addr = in_pix ? col_q : 9'd0;
    assign buf_data = in_pix ? {prio_q, pal_q, pix} : 12'd0;

    always_comb begin
        state_d    = state_q;
        pix_cnt_d  = pix_cnt_q;
        word_cnt_d = word_cnt_q;
        addr_d     = addr_q;
        flip_d     = flip_q;
        bank_d     = bank_q;
        prio_d     = prio_q;
        pal_d      = pal_q;
        col_d      = col_q;
        data_d     = data_q;
        obj_cs_d   = obj_cs_q;
        obj_addr_d = obj_addr_q;
        cs_prev_d  = obj_cs_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    col_d      = xpos;
                    flip_d     = offset[15];
                    addr_d     = offset[14:0];
                    bank_d     = bank;
                    prio_d     = prio;
                    pal_d      = pal;
                    word_cnt_d = '0;
                    obj_cs_d   = 1'b1;
                    obj_addr_d = {bank, offset[14:0]};
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                // A valid already present when the strobe rises is stale.
                if (obj_cs_q && cs_prev_q && obj_ok) begin
                    data_d     = obj_data;
                    obj_cs_d   = 1'b0;
                    word_cnt_d = word_cnt_q + WCW'(1);
                    pix_cnt_d  = 2'd0;
                    state_d    = ST_PIX;
                end
            end
            ST_PIX: begin
                if (pix == 4'hF) begin
                    state_d = ST_IDLE;
                end else begin
                    col_d     = col_q + 9'd1;
                    pix_cnt_d = pix_cnt_q + 2'd1;
                    if (pix_cnt_q == 2'd3) begin
                        if (word_cnt_q == MAXW_W) begin
                            state_d = ST_IDLE;
                        end else begin
                            addr_d     = flip_q ? addr_q - 15'd1 : addr_q + 15'd1;
                            obj_cs_d   = 1'b1;
                            obj_addr_d = {bank_q, addr_d};
                            state_d    = ST_REQ;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pix_cnt_q  <= 2'd0;
            word_cnt_q <= '0;
            addr_q     <= 15'd0;
            flip_q     <= 1'b0;
            bank_q     <= 4'd0;
            prio_q     <= 2'd0;
            pal_q      <= 6'd0;
            col_q      <= 9'd0;
            data_q     <= 16'd0;
            obj_cs_q   <= 1'b0;
            cs_prev_q  <= 1'b0;
            obj_addr_q <= 19'd0;
        end else begin
            state_q    <= state_d;
            pix_cnt_q  <= pix_cnt_d;
            word_cnt_q <= word_cnt_d;
            addr_q     <= addr_d;
            flip_q     <= flip_d;
            bank_q     <= bank_d;
            prio_q     <= prio_d;
            pal_q      <= pal_d;
            col_q      <= col_d;
            data_q     <= data_d;
            obj_cs_q   <= obj_cs_d;
            cs_prev_q  <= cs_prev_d;
            obj_addr_q <= obj_addr_d;
        end
    end

endmodule
